dmem_bytelane: RTL and testbench

Parametrised data memory for the single-cycle CPU, replacing the fixed 256×32 word-addressed RAM. It takes byte addresses and supports byte, halfword and word access with per-lane writes and sign- or zero-extended loads. It flags misaligned and out-of-range accesses. A hardware clear sequencer zeroes the array one word per cycle after reset or on request. It sits between the ALU address/store-data path and the writeback mux.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_align.sv | 67 ++++++
 rtl/dmem_bytelane.sv | 110 +++++++++++
 tb/tb_dmem_bytelane.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the byte-lane data memory: access sizes and clear-FSM states.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dmem_state_e;

  // Right-aligned extension of a byte or halfword load value.
  function automatic logic [31:0] extend_load(input logic [15:0] value,
                                              input logic        is_half,
                                              input logic        zero_ext);
    logic sign_bit;
    sign_bit = is_half ? value[15] : value[7];
    if (is_half)
      return {{16{sign_bit & ~zero_ext}}, value};
    else
      return {{24{sign_bit & ~zero_ext}}, value[7:0]};
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational lane logic: load select/extend, store byte enables and data
// replication, and alignment/size fault detection.
module dmem_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        ld_unsigned,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] rdata_ext,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lanes,
  output logic        misaligned,
  output logic        reserved
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte = 8'h00;
    case (lane)
      2'd0:    rbyte = rword[7:0];
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
  end

  assign rhalf = lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    rdata_ext = 32'h0000_0000;
    case (size)
      SZ_BYTE: rdata_ext = extend_load({8'h00, rbyte}, 1'b0, ld_unsigned);
      SZ_HALF: rdata_ext = extend_load(rhalf, 1'b1, ld_unsigned);
      SZ_WORD: rdata_ext = rword;
      default: rdata_ext = 32'h0000_0000;
    endcase
  end

  // Replicating store data into every lane lets each lane just pick its own byte.
  always_comb begin
    wdata_lanes = wdata;
    case (size)
      SZ_BYTE: wdata_lanes = {4{wdata[7:0]}};
      SZ_HALF: wdata_lanes = {2{wdata[15:0]}};
      default: wdata_lanes = wdata;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_be
      localparam logic [1:0] LANE = 2'(gi);
      assign byte_en[gi] = ((size == SZ_BYTE) && (lane == LANE)) ||
                           ((size == SZ_HALF) && (lane[1] == LANE[1])) ||
                           (size == SZ_WORD);
    end
  endgenerate

  assign misaligned = ((size == SZ_HALF) && lane[0]) ||
                      ((size == SZ_WORD) && (lane != 2'b00));
  assign reserved   = (size == SZ_RSVD);

endmodule

// File: rtl/dmem_bytelane.sv
// Byte-addressed data memory with per-lane stores, extended loads, fault
// detection and a one-word-per-cycle hardware clear sequencer.
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr_req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  dmem_state_e   state_reg, state_next;
  logic [AW-1:0] ptr_reg, ptr_next;

  logic [AW-1:0] word_idx;
  logic          out_of_range;
  logic          misaligned;
  logic          reserved;
  logic          store_ok;
  logic [3:0]    byte_en;
  logic [31:0]   wdata_lanes;
  logic [31:0]   rword;
  logic [31:0]   rdata_ext;
  logic [7:0]    rbytes [4];

  assign word_idx     = addr[AW+1:2];
  assign out_of_range = |addr[31:AW+2];
  assign fault        = misaligned | reserved | out_of_range;
  assign busy         = (state_reg == CLEAR);
  assign store_ok     = we & ~fault & ~busy;

  dmem_align u_align (
    .size        (size),
    .lane        (addr[1:0]),
    .ld_unsigned (ld_unsigned),
    .rword       (rword),
    .wdata       (wdata),
    .rdata_ext   (rdata_ext),
    .byte_en     (byte_en),
    .wdata_lanes (wdata_lanes),
    .misaligned  (misaligned),
    .reserved    (reserved)
  );

  // One independent byte-wide array per lane; the clear sequencer owns all
  // write ports while busy, so stores cannot race the zeroing.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge clk) begin
        if (busy)
          lane_mem[ptr_reg] <= 8'h00;
        else if (store_ok && byte_en[gi])
          lane_mem[word_idx] <= wdata_lanes[8*gi +: 8];
      end

      assign rbytes[gi] = lane_mem[word_idx];
    end
  endgenerate

  assign rword = {rbytes[3], rbytes[2], rbytes[1], rbytes[0]};
  assign rdata = (fault | busy) ? 32'h0000_0000 : rdata_ext;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      CLEAR: begin
        if (ptr_reg == AW'(DEPTH - 1))
          state_next = READY;
        else
          ptr_next = ptr_reg + AW'(1);
      end
      READY: begin
        if (clr_req) begin
          state_next = CLEAR;
          ptr_next   = '0;
        end
      end
      default: begin
        state_next = CLEAR;
        ptr_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= CLEAR;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

endmodule

// File: tb/tb_dmem_bytelane.sv
// Self-checking bench for dmem_bytelane against a byte-array reference model.
module tb_dmem_bytelane;

  localparam int DEPTH  = 256;
  localparam int NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clr_req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        ld_unsigned = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        fault;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_m [NBYTES];
  int         clear_left = DEPTH;

  dmem_bytelane #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clr_req     (clr_req),
    .we          (we),
    .size        (size),
    .ld_unsigned (ld_unsigned),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .fault       (fault),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic logic exp_fault(input logic [31:0] a, input logic [1:0] s);
    if (a >= 32'(NBYTES)) return 1'b1;
    if (s == 2'd3) return 1'b1;
    if (s == 2'd1 && a[0]) return 1'b1;
    if (s == 2'd2 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] s, input logic u);
    int   base;
    logic [31:0] v;
    if (exp_fault(a, s) || clear_left > 0) return 32'h0;
    base = int'(a);
    v = 32'h0;
    for (int i = 0; i < (1 << s); i++)
      v = v | (32'(mem_m[base + i]) << (8 * i));
    if (!u && s == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (!u && s == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  // Advance one rising edge, applying the reference behaviour for that edge.
  task automatic tick();
    if (!reset_n) begin
      clear_left = DEPTH;
    end else if (clear_left > 0) begin
      clear_left--;
    end else begin
      if (we && !exp_fault(addr, size))
        for (int i = 0; i < (1 << size); i++)
          mem_m[int'(addr) + i] = wdata[8*i +: 8];
      if (clr_req) begin
        clear_left = DEPTH;
        foreach (mem_m[i]) mem_m[i] = 8'h00;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] s, input logic u,
                       input logic w, input logic [31:0] d);
    addr = a; size = s; ld_unsigned = u; we = w; wdata = d;
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    drive(a, s, 1'b0, 1'b1, d);
    $display("ST addr=%h size=%0d data=%h fault=%b busy=%b", a, s, d, fault, busy);
    tick();
    we = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    int busy_cnt;
    reset_n = 1'b0;
    clear_left = DEPTH;
    foreach (mem_m[i]) mem_m[i] = 8'h00;
    drive(32'h3FC, 2'd2, 1'b0, 1'b0, 32'h0);
    repeat (3) tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fault); end
    reset_n = 1'b1;
    #1;
    busy_cnt = busy ? 1 : 0;
    for (int i = 1; i <= DEPTH; i++) begin
      tick();
      if (busy) busy_cnt++;
      checks++;
      if (busy !== (clear_left > 0)) begin
        errors++; $display("FAIL clear_busy edge %0d: got %b expected %b", i, busy, clear_left > 0);
      end
      checks++;
      if (rdata !== exp_load(addr, size, ld_unsigned)) begin
        errors++; $display("FAIL clear_rdata edge %0d: got %h expected %h", i, rdata, exp_load(addr, size, ld_unsigned));
      end
    end
    $display("RESET busy cycles=%0d", busy_cnt);
    checks++;
    if (busy_cnt !== DEPTH) begin errors++; $display("FAIL reset_busy_len: got %0d expected %0d", busy_cnt, DEPTH); end
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL cleared_3fc: got %h expected 0", rdata); end
    do_store(32'h3FC, 2'd2, 32'h5A5A_1234);
    drive(32'h3FC, 2'd2, 1'b0, 1'b0, 32'h0);
    $display("LD addr=%h size=2 rdata=%h", addr, rdata);
    checks++;
    if (rdata !== 32'h5A5A_1234) begin errors++; $display("FAIL first_store: got %h expected 5a5a1234", rdata); end
  endtask

  task automatic test_load_ext();
    logic [31:0] la [6] = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h12, 32'h10};
    logic [1:0]  ls [6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
    logic        lu [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] le [6] = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF,
                            32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};
    do_store(32'h10, 2'd2, 32'h80FF_7F01);
    for (int i = 0; i < 6; i++) begin
      drive(la[i], ls[i], lu[i], 1'b0, 32'h0);
      $display("LD addr=%h size=%0d uns=%b rdata=%h fault=%b", la[i], ls[i], lu[i], rdata, fault);
      checks++;
      if (rdata !== le[i]) begin errors++; $display("FAIL load_ext %0d: got %h expected %h", i, rdata, le[i]); end
      checks++;
      if (rdata !== exp_load(la[i], ls[i], lu[i])) begin
        errors++; $display("FAIL load_model %0d: got %h expected %h", i, rdata, exp_load(la[i], ls[i], lu[i]));
      end
      checks++;
      if (fault !== 1'b0) begin errors++; $display("FAIL load_fault %0d: got %b expected 0", i, fault); end
    end
  endtask

  task automatic test_partial_store();
    do_store(32'h20, 2'd2, 32'h1122_3344);
    do_store(32'h21, 2'd0, 32'h1234_56AA);
    drive(32'h20, 2'd2, 1'b0, 1'b0, 32'h0);
    $display("LD addr=%h size=2 rdata=%h", addr, rdata);
    checks++;
    if (rdata !== 32'h1122_AA44) begin errors++; $display("FAIL sb_merge: got %h expected 1122aa44", rdata); end
    // Store in flight to the word being read: old data until the edge.
    drive(32'h22, 2'd1, 1'b0, 1'b1, 32'h5555_BEEF);
    $display("ST addr=%h size=1 data=%h rdata_before=%h", addr, wdata, rdata);
    checks++;
    if (rdata !== 32'h0000_1122) begin errors++; $display("FAIL same_cycle_old: got %h expected 00001122", rdata); end
    tick();
    drive(32'h20, 2'd2, 1'b0, 1'b0, 32'h0);
    $display("LD addr=%h size=2 rdata=%h", addr, rdata);
    checks++;
    if (rdata !== 32'hBEEF_AA44) begin errors++; $display("FAIL sh_merge: got %h expected beefaa44", rdata); end
  endtask

  task automatic test_faults();
    drive(32'h22, 2'd2, 1'b0, 1'b1, 32'hDEAD_BEEF);
    $display("ST addr=%h size=2 fault=%b rdata=%h", addr, fault, rdata);
    checks++;
    if (fault !== 1'b1) begin errors++; $display("FAIL sw_misalign_fault: got %b expected 1", fault); end
    tick();
    we = 1'b0;
    drive(32'h20, 2'd2, 1'b0, 1'b0, 32'h0);
    checks++;
    if (rdata !== 32'hBEEF_AA44) begin errors++; $display("FAIL sw_misalign_kept: got %h expected beefaa44", rdata); end
    drive(32'h23, 2'd1, 1'b0, 1'b0, 32'h0);
    $display("LD addr=%h size=1 fault=%b rdata=%h", addr, fault, rdata);
    checks++;
    if (rdata !== 32'h0 || fault !== 1'b1) begin
      errors++; $display("FAIL lh_misalign: got rdata=%h fault=%b expected 0/1", rdata, fault);
    end
    drive(32'h20, 2'd3, 1'b0, 1'b0, 32'h0);
    $display("LD addr=%h size=3 fault=%b rdata=%h", addr, fault, rdata);
    checks++;
    if (fault !== 1'b1 || rdata !== 32'h0) begin
      errors++; $display("FAIL size_rsvd: got fault=%b rdata=%h expected 1/0", fault, rdata);
    end
    do_store(32'h0, 2'd2, 32'hCAFE_F00D);
    drive(32'h400, 2'd2, 1'b0, 1'b1, 32'h1234_5678);
    $display("ST addr=%h size=2 fault=%b", addr, fault);
    checks++;
    if (fault !== 1'b1) begin errors++; $display("FAIL oor_fault: got %b expected 1", fault); end
    tick();
    we = 1'b0;
    drive(32'h0, 2'd2, 1'b0, 1'b0, 32'h0);
    checks++;
    if (rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL oor_kept: got %h expected cafef00d", rdata); end
    drive(32'h8000_0010, 2'd0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (fault !== 1'b1 || rdata !== 32'h0) begin
      errors++; $display("FAIL oor_high: got fault=%b rdata=%h expected 1/0", fault, rdata);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [1:0]  s;
    logic        u, w;
    logic [31:0] d;
    for (int n = 0; n < 300; n++) begin
      a = 32'($urandom_range(0, NBYTES + 15));
      if ($urandom_range(0, 2) != 0) a = a & ~32'((1 << $urandom_range(0, 2)) - 1);
      if ($urandom_range(0, 31) == 0) a = $urandom;
      s = 2'($urandom_range(0, 3));
      u = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      drive(a, s, u, w, d);
      $display("RND %0d we=%b addr=%h size=%0d uns=%b wdata=%h rdata=%h fault=%b", n, w, a, s, u, d, rdata, fault);
      checks++;
      if (fault !== exp_fault(a, s)) begin errors++; $display("FAIL rnd_fault %0d: got %b expected %b", n, fault, exp_fault(a, s)); end
      checks++;
      if (rdata !== exp_load(a, s, u)) begin errors++; $display("FAIL rnd_rdata %0d: got %h expected %h", n, rdata, exp_load(a, s, u)); end
      tick();
      we = 1'b0;
    end
  endtask

  task automatic test_clr_req();
    int busy_cnt;
    int bad;
    do_store(32'h40, 2'd2, 32'h0BAD_F00D);
    drive(32'h40, 2'd2, 1'b0, 1'b0, 32'h0);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL clr_pre_busy: got %b expected 0", busy); end
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < DEPTH + 20 && busy; i++) begin
      busy_cnt++;
      if (i == 50) begin drive(32'h40, 2'd2, 1'b0, 1'b1, 32'hDEAD_BEEF); clr_req = 1'b1; end
      if (i == 52) begin we = 1'b0; clr_req = 1'b0; end
      tick();
      checks++;
      if (busy !== (clear_left > 0)) begin
        errors++; $display("FAIL clr_busy %0d: got %b expected %b", i, busy, clear_left > 0);
      end
    end
    we = 1'b0; clr_req = 1'b0;
    $display("CLR busy cycles=%0d", busy_cnt);
    checks++;
    if (busy_cnt !== DEPTH) begin errors++; $display("FAIL clr_len: got %0d expected %0d", busy_cnt, DEPTH); end
    bad = 0;
    for (int wi = 0; wi < DEPTH; wi++) begin
      drive(32'(wi * 4), 2'd2, 1'b0, 1'b0, 32'h0);
      if (rdata !== 32'h0) bad++;
    end
    $display("CLR sweep nonzero words=%0d", bad);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL clr_sweep: got %0d nonzero words expected 0", bad); end
  endtask

  task automatic test_reset_mid_clear();
    int busy_cnt;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (99) tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midclr_busy: got %b expected 1", busy); end
    reset_n = 1'b0;
    clear_left = DEPTH;
    tick();
    reset_n = 1'b1;
    #1;
    busy_cnt = 0;
    for (int i = 0; i < DEPTH + 20 && busy; i++) begin
      busy_cnt++;
      tick();
      checks++;
      if (busy !== (clear_left > 0)) begin
        errors++; $display("FAIL rst_busy %0d: got %b expected %b", i, busy, clear_left > 0);
      end
    end
    $display("RSTMID busy cycles=%0d", busy_cnt);
    checks++;
    if (busy_cnt !== DEPTH) begin errors++; $display("FAIL rst_len: got %0d expected %0d", busy_cnt, DEPTH); end
    do_store(32'h1E, 2'd1, 32'h0000_8001);
    drive(32'h1E, 2'd1, 1'b1, 1'b0, 32'h0);
    $display("LD addr=%h size=1 uns=1 rdata=%h", addr, rdata);
    checks++;
    if (rdata !== 32'h0000_8001) begin errors++; $display("FAIL post_rst_store: got %h expected 00008001", rdata); end
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_partial_store();
    test_faults();
    test_random();
    test_clr_req();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
